// File: rtl/fpro_bridge_pkg.sv
// Shared state encoding, command-byte layout and frame geometry for the
// FPro UART bridge master and its response shifter.
package fpro_bridge_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  localparam int WR_BIT = 7;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_DEFAULT = 8'h5A;

  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 4;

endpackage

// File: rtl/fpro_bridge_tx_shift.sv
// 32-bit response shifter: emits load_count_i bytes MSB first through a
// valid/ready stage and pulses done_o on the final handshake.
module fpro_bridge_tx_shift (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        load_i,
  input  logic [31:0] load_word_i,
  input  logic [2:0]  load_count_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        done_o
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        handshake;

  assign handshake = valid_q && tx_ready_i;
  assign done_o    = handshake && (count_q == 3'd1);

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = load_word_i;
      count_d = load_count_i;
      valid_d = 1'b1;
    end else if (handshake) begin
      if (count_q == 3'd1) begin
        count_d = 3'd0;
        valid_d = 1'b0;
      end else begin
        shift_d = {shift_q[23:0], 8'h00};
        count_d = count_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o  = shift_q[31:24];
  assign tx_valid_o = valid_q;

endmodule

// File: rtl/fpro_uart_bridge_master.sv
// Byte-stream command parser acting as FPro MMIO bus initiator.
// Define FRAME_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES idle.
module fpro_uart_bridge_master
  import fpro_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 21,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  mmio_cs_o,
  output logic                  mmio_read_o,
  output logic                  mmio_write_o,
  output logic [ADDR_WIDTH-1:0] mmio_addr_o,
  output logic [31:0]           mmio_wr_data_o,
  input  logic [31:0]           mmio_rd_data_i,
  output logic                  busy_o
);

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_sh_q, addr_sh_d;
  logic [31:0]             data_sh_q, data_sh_d;
  logic                    cs_q, cs_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   mmio_addr_q, mmio_addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rx_ready_q, rx_ready_d;

  logic                    rx_fire;
  logic                    timeout_hit;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [31:0]             data_next;
  logic                    tx_load;
  logic [31:0]             tx_word;
  logic [2:0]              tx_count;
  logic                    tx_done;

  assign rx_fire   = rx_valid_i && rx_ready_q;
  // Shifting into an ADDR_WIDTH register drops the unused upper address bits.
  assign addr_next = {addr_sh_q[ADDR_WIDTH-9:0], rx_data_i};
  assign data_next = {data_sh_q[23:0], rx_data_i};

`ifdef FRAME_TIMEOUT_EN
  logic [19:0] idle_q, idle_d;
  logic        in_frame;

  assign in_frame    = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign timeout_hit = in_frame && !rx_fire && (idle_q == 20'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if (in_frame && !rx_fire && !timeout_hit) begin
      idle_d = idle_q + 20'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    cs_d        = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    mmio_addr_d = mmio_addr_q;
    wdata_d     = wdata_q;
    tx_load     = 1'b0;
    tx_word     = '0;
    tx_count    = 3'd1;

    unique case (state_q)
      ST_CMD: begin
        if (rx_fire) begin
          if (rx_data_i[WR_BIT-1:0] != '0) begin
            tx_load = 1'b1;
            tx_word = {NAK_BYTE, 24'h000000};
            state_d = ST_RESP;
          end else begin
            is_wr_d = rx_data_i[WR_BIT];
            cnt_d   = 2'd0;
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (rx_fire) begin
          addr_sh_d = addr_next;
          if (cnt_q == 2'(ADDR_BYTES - 1)) begin
            cnt_d = 2'd0;
            if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              state_d     = ST_BUS;
              cs_d        = 1'b1;
              rd_d        = 1'b1;
              mmio_addr_d = addr_next;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (timeout_hit) begin
          cnt_d   = 2'd0;
          state_d = ST_CMD;
        end
      end

      ST_DATA: begin
        if (rx_fire) begin
          data_sh_d = data_next;
          if (cnt_q == 2'(DATA_BYTES - 1)) begin
            cnt_d       = 2'd0;
            state_d     = ST_BUS;
            cs_d        = 1'b1;
            wr_d        = 1'b1;
            mmio_addr_d = addr_sh_q;
            wdata_d     = data_next;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (timeout_hit) begin
          cnt_d   = 2'd0;
          state_d = ST_CMD;
        end
      end

      // Read data is only valid while the strobe is on the bus, so capture it here.
      ST_BUS: begin
        tx_load  = 1'b1;
        tx_word  = is_wr_q ? {ACK_BYTE, 24'h000000} : mmio_rd_data_i;
        tx_count = is_wr_q ? 3'd1 : 3'(DATA_BYTES);
        state_d  = ST_RESP;
      end

      ST_RESP: begin
        if (tx_done) begin
          state_d = ST_CMD;
        end
      end

      default: state_d = ST_CMD;
    endcase

    rx_ready_d = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_DATA);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_CMD;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mmio_addr_q <= '0;
      wdata_q     <= '0;
      rx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mmio_addr_q <= mmio_addr_d;
      wdata_q     <= wdata_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  fpro_bridge_tx_shift u_tx_shift (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .load_i       (tx_load),
    .load_word_i  (tx_word),
    .load_count_i (tx_count),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .done_o       (tx_done)
  );

  assign rx_ready_o     = rx_ready_q;
  assign mmio_cs_o      = cs_q;
  assign mmio_read_o    = rd_q;
  assign mmio_write_o   = wr_q;
  assign mmio_addr_o    = mmio_addr_q;
  assign mmio_wr_data_o = wdata_q;
  assign busy_o         = (state_q != ST_CMD);

endmodule

// File: tb/tb_fpro_uart_bridge_master.sv
// Self-checking bench for fpro_uart_bridge_master: frame-level reference model,
// logged bus cycles and response bytes compared per scenario.
module tb_fpro_uart_bridge_master;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          mmio_cs, mmio_read, mmio_write;
  logic [AW-1:0] mmio_addr;
  logic [31:0]   mmio_wr_data, mmio_rd_data;
  logic          busy;

  logic [31:0]   rd_value;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            last_acc_cyc = 0;
  bit            rand_rdy = 1'b0;

  fpro_uart_bridge_master #(
    .ADDR_WIDTH     (AW),
    .ACK_BYTE       (8'hA5),
    .NAK_BYTE       (8'h5A),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .mmio_cs_o      (mmio_cs),
    .mmio_read_o    (mmio_read),
    .mmio_write_o   (mmio_write),
    .mmio_addr_o    (mmio_addr),
    .mmio_wr_data_o (mmio_wr_data),
    .mmio_rd_data_i (mmio_rd_data),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave returns the programmed word only during a read strobe; garbage otherwise.
  assign mmio_rd_data = (mmio_cs && mmio_read) ? rd_value : ~rd_value;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            cyc;
  } bus_ev_t;

  bus_ev_t    bus_log[$];
  logic [7:0] tx_log[$];
  int         tx_rise_cyc[$];
  logic       tx_valid_prev = 1'b0;

  always @(negedge clk) begin
    if (mmio_cs) bus_log.push_back('{mmio_read, mmio_write, mmio_addr, mmio_wr_data, cyc});
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (tx_valid && !tx_valid_prev) tx_rise_cyc.push_back(cyc);
    tx_valid_prev <= tx_valid;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: frame-level rules only.
  logic [7:0]    exp_tx[$];
  int            exp_bus_n;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata;
  logic [31:0]   last_wdata = 32'h0;

  task automatic model_frame(input logic [7:0] cmd, input logic [23:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdv);
    exp_tx.delete();
    if (cmd[6:0] != 7'd0) begin
      exp_bus_n = 0;
      exp_tx.push_back(8'h5A);
    end else begin
      exp_bus_n = 1;
      exp_wr    = cmd[7];
      exp_addr  = addr[AW-1:0];
      if (cmd[7]) begin
        last_wdata = wdata;
        exp_tx.push_back(8'hA5);
      end else begin
        for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(rdv >> (8 * i)));
      end
      exp_wdata = last_wdata;
    end
  endtask

  task automatic clear_logs();
    bus_log.delete();
    tx_log.delete();
    tx_rise_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 right after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end
    last_acc_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [23:0] addr, input logic [31:0] wdata);
    send_byte(cmd);
    if (cmd[6:0] == 7'd0) begin
      for (int i = 2; i >= 0; i--) send_byte(8'(addr >> (8 * i)));
      if (cmd[7]) for (int i = 3; i >= 0; i--) send_byte(8'(wdata >> (8 * i)));
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || tx_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy || tx_valid) begin
      fails++;
      $display("FAIL %s idle_timeout: busy=%b tx_valid=%b required 0/0", name, busy, tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    rd_value = 32'h0;
    last_wdata = 32'h0;
    repeat (2) @(negedge clk);
    tests++;
    if ({rx_ready, tx_valid, tx_data, mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data, busy} !== '0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b txv=%b txd=%h cs=%b rd=%b wr=%b addr=%h wd=%h busy=%b required all 0",
               rx_ready, tx_valid, tx_data, mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data, busy);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rx_ready=%b busy=%b required 1/0", rx_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    model_frame(8'h80, 24'h0000A5, 32'h12345678, 32'h0);
    clear_logs();
    send_frame(8'h80, 24'h0000A5, 32'h12345678);
    wait_idle("write");
    tests++;
    if (bus_log.size() != 1) begin
      fails++;
      $display("FAIL write bus_count: got %0d required 1", bus_log.size());
    end else begin
      tests++;
      if (bus_log[0].wr !== 1'b1 || bus_log[0].rd !== 1'b0 || bus_log[0].addr !== 21'h0000A5 ||
          bus_log[0].wdata !== 32'h12345678) begin
        fails++;
        $display("FAIL write bus_cycle: rd=%b wr=%b addr=%h wd=%h required 0/1/0000a5/12345678",
                 bus_log[0].rd, bus_log[0].wr, bus_log[0].addr, bus_log[0].wdata);
      end
      tests++;
      if (bus_log[0].cyc != last_acc_cyc + 1) begin
        fails++;
        $display("FAIL write cs_latency: cs at cycle %0d required %0d", bus_log[0].cyc, last_acc_cyc + 1);
      end
    end
    tests++;
    if (tx_rise_cyc.size() < 1 || tx_rise_cyc[0] != last_acc_cyc + 2) begin
      fails++;
      $display("FAIL write txv_latency: rise cycle %0d required %0d",
               (tx_rise_cyc.size() > 0) ? tx_rise_cyc[0] : -1, last_acc_cyc + 2);
    end
    tests++;
    if (tx_log.size() != 1 || tx_log[0] !== exp_tx[0]) begin
      fails++;
      $display("FAIL write tx_bytes: count %0d first %h required 1 byte %h",
               tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'hxx, exp_tx[0]);
    end
  endtask

  task automatic test_read();
    rd_value = 32'hDEADBEEF;
    model_frame(8'h00, 24'h000140, 32'h0, rd_value);
    clear_logs();
    send_frame(8'h00, 24'h000140, 32'h0);
    wait_idle("read");
    tests++;
    if (bus_log.size() != 1) begin
      fails++;
      $display("FAIL read bus_count: got %0d required 1", bus_log.size());
    end else begin
      tests++;
      if (bus_log[0].rd !== 1'b1 || bus_log[0].wr !== 1'b0 || bus_log[0].addr !== exp_addr ||
          bus_log[0].wdata !== exp_wdata) begin
        fails++;
        $display("FAIL read bus_cycle: rd=%b wr=%b addr=%h wd=%h required 1/0/%h/%h",
                 bus_log[0].rd, bus_log[0].wr, bus_log[0].addr, bus_log[0].wdata, exp_addr, exp_wdata);
      end
      tests++;
      if (bus_log[0].cyc != last_acc_cyc + 1) begin
        fails++;
        $display("FAIL read cs_latency: cs at cycle %0d required %0d", bus_log[0].cyc, last_acc_cyc + 1);
      end
    end
    tests++;
    if (tx_log.size() != 4) begin
      fails++;
      $display("FAIL read tx_count: got %0d required 4", tx_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (tx_log[i] !== exp_tx[i]) begin
          fails++;
          $display("FAIL read tx_byte%0d: got %h required %h", i, tx_log[i], exp_tx[i]);
        end
      end
    end
  endtask

  // One randomized-or-fixed frame checked against the model.
  task automatic test_frame(input string name, input logic [7:0] cmd, input logic [23:0] addr,
                            input logic [31:0] wdata);
    rd_value = $urandom;
    model_frame(cmd, addr, wdata, rd_value);
    clear_logs();
    send_frame(cmd, addr, wdata);
    wait_idle(name);
    tests++;
    if (bus_log.size() != exp_bus_n) begin
      fails++;
      $display("FAIL %s bus_count: got %0d required %0d (cmd %h)", name, bus_log.size(), exp_bus_n, cmd);
    end else if (exp_bus_n == 1) begin
      tests++;
      if (bus_log[0].wr !== exp_wr || bus_log[0].rd !== !exp_wr || bus_log[0].addr !== exp_addr ||
          bus_log[0].wdata !== exp_wdata) begin
        fails++;
        $display("FAIL %s bus_cycle: rd=%b wr=%b addr=%h wd=%h required %b/%b/%h/%h", name,
                 bus_log[0].rd, bus_log[0].wr, bus_log[0].addr, bus_log[0].wdata,
                 !exp_wr, exp_wr, exp_addr, exp_wdata);
      end
    end
    tests++;
    if (tx_log.size() != exp_tx.size()) begin
      fails++;
      $display("FAIL %s tx_count: got %0d required %0d", name, tx_log.size(), exp_tx.size());
    end else begin
      for (int i = 0; i < exp_tx.size(); i++) begin
        tests++;
        if (tx_log[i] !== exp_tx[i]) begin
          fails++;
          $display("FAIL %s tx_byte%0d: got %h required %h", name, i, tx_log[i], exp_tx[i]);
        end
      end
    end
  endtask

  task automatic test_malformed();
    test_frame("malformed", 8'h41, 24'h0, 32'h0);
    test_frame("after_nak_read", 8'h00, 24'($urandom), 32'h0);
  endtask

  task automatic test_backpressure();
    logic [23:0] addr;
    addr     = 24'($urandom);
    rd_value = $urandom;
    model_frame(8'h00, addr, 32'h0, rd_value);
    clear_logs();
    tx_ready = 1'b0;
    send_frame(8'h00, addr, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== exp_tx[i] || rx_ready !== 1'b0) begin
          fails++;
          $display("FAIL backpressure stall%0d_%0d: txv=%b txd=%h rx_ready=%b required 1/%h/0",
                   i, k, tx_valid, tx_data, rx_ready, exp_tx[i]);
        end
        @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL backpressure end: txv=%b busy=%b required 0/0", tx_valid, busy);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    tests++;
    if (tx_log.size() != 4 || bus_log.size() != 1) begin
      fails++;
      $display("FAIL backpressure counts: tx %0d bus %0d required 4/1", tx_log.size(), bus_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (tx_log[i] !== exp_tx[i]) begin
          fails++;
          $display("FAIL backpressure tx_byte%0d: got %h required %h", i, tx_log[i], exp_tx[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    send_byte(8'h80);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    reset_n = 1'b0;
    last_wdata = 32'h0;
    @(negedge clk);
    tests++;
    if ({rx_ready, tx_valid, tx_data, mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data, busy} !== '0) begin
      fails++;
      $display("FAIL midreset_values: rdy=%b txv=%b txd=%h cs=%b rd=%b wr=%b addr=%h wd=%h busy=%b required all 0",
               rx_ready, tx_valid, tx_data, mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data, busy);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus_log.size() != 0 || tx_log.size() != 0) begin
      fails++;
      $display("FAIL midreset_discard: bus %0d tx %0d required 0/0", bus_log.size(), tx_log.size());
    end
    test_frame("post_reset_write", 8'h80, 24'($urandom), $urandom);
  endtask

  task automatic test_back_to_back();
    logic [23:0] a1, a2;
    logic [31:0] r1, r2;
    logic [7:0]  all_tx[$];
    int          hs_cyc = -1;
    int          acc_cyc = -1;
    a1 = 24'($urandom);
    a2 = 24'($urandom);
    r1 = $urandom;
    r2 = $urandom;
    model_frame(8'h00, a1, 32'h0, r1);
    all_tx = exp_tx;
    model_frame(8'h00, a2, 32'h0, r2);
    foreach (exp_tx[i]) all_tx.push_back(exp_tx[i]);
    clear_logs();
    rd_value = r1;
    send_frame(8'h00, a1, 32'h0);
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        acc_cyc = cyc;
        break;
      end
      if (tx_valid && tx_ready) hs_cyc = cyc;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rd_value = r2;
    tests++;
    if (acc_cyc < 0 || acc_cyc != hs_cyc + 1) begin
      fails++;
      $display("FAIL b2b cmd_accept: accept cycle %0d required %0d", acc_cyc, hs_cyc + 1);
    end
    for (int i = 2; i >= 0; i--) send_byte(8'(a2 >> (8 * i)));
    wait_idle("b2b");
    tests++;
    if (bus_log.size() != 2 || tx_log.size() != 8) begin
      fails++;
      $display("FAIL b2b counts: bus %0d tx %0d required 2/8", bus_log.size(), tx_log.size());
    end else begin
      tests++;
      if (bus_log[0].addr !== a1[AW-1:0] || bus_log[1].addr !== a2[AW-1:0] ||
          bus_log[0].rd !== 1'b1 || bus_log[1].rd !== 1'b1) begin
        fails++;
        $display("FAIL b2b bus: addr %h/%h rd %b/%b required %h/%h 1/1", bus_log[0].addr, bus_log[1].addr,
                 bus_log[0].rd, bus_log[1].rd, a1[AW-1:0], a2[AW-1:0]);
      end
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (tx_log[i] !== all_tx[i]) begin
          fails++;
          $display("FAIL b2b tx_byte%0d: got %h required %h", i, tx_log[i], all_tx[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int          kind;
      logic [7:0]  cmd;
      kind = $urandom_range(0, 9);
      if (kind == 0) cmd = {1'($urandom), 7'($urandom_range(1, 127))};
      else if (kind <= 4) cmd = 8'h80;
      else cmd = 8'h00;
      test_frame("random", cmd, 24'($urandom), $urandom);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    send_byte(8'h80);
    send_byte(8'h00);
    for (int j = 1; j <= 105; j++) begin
      @(negedge clk);
      if (j == 95) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL timeout early: busy=%b required 1 at idle cycle 95", busy);
        end
      end
    end
    tests++;
    if (busy !== 1'b0 || rx_ready !== 1'b1 || bus_log.size() != 0 || tx_log.size() != 0) begin
      fails++;
      $display("FAIL timeout drop: busy=%b rx_ready=%b bus %0d tx %0d required 0/1/0/0",
               busy, rx_ready, bus_log.size(), tx_log.size());
    end
    @(posedge clk); #1;
    test_frame("post_timeout_read", 8'h00, 24'($urandom), 32'h0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_malformed();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
`ifdef FRAME_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpro_uart_bridge_master.md
Name: fpro_uart_bridge_master

Overview:
- Bus initiator for the FPro MMIO bus. It takes the place of the MicroBlaze MCS as the driver of mmio_cs/read/write/addr/wr_data.
- Parses a byte-stream command protocol, fed from a host link such as a UART receiver FIFO. Issues single-cycle FPro read/write transactions.
- Returns read data or an acknowledge as a byte stream.
- Used as a board-level debug/bring-up path into every slot (timer, uart, sseg, gpio, xadc) without firmware.

Parameters:
- ADDR_WIDTH, 21, width of mmio_addr; address is carried in 3 frame bytes, upper (24-ADDR_WIDTH) bits discarded.
- ACK_BYTE, 8'hA5, response byte for a completed write.
- NAK_BYTE, 8'h5A, response byte for a malformed command byte.
- TIMEOUT_CYCLES, 1_000_000, inter-byte idle limit; used only with FRAME_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- rx_data  in  8  incoming command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts byte; transfer occurs when rx_valid && rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready
- tx_ready  in  1  sink accepts response byte
- mmio_cs  out  1  FPro bus chip select
- mmio_read  out  1  FPro read strobe
- mmio_write  out  1  FPro write strobe
- mmio_addr  out  ADDR_WIDTH  FPro address
- mmio_wr_data  out  32  FPro write data
- mmio_rd_data  in  32  FPro read data, valid in the same cycle as mmio_cs && mmio_read
- busy  out  1  high in any state other than CMD

Behaviour:
- Frame format: CMD byte, then 3 address bytes MSB first, then, for writes only, 4 data bytes MSB first.
- CMD byte: bit7 = 1 write / 0 read; bits[6:0] must be 0.
- Response: a read returns 4 bytes of rd_data, MSB first. A write returns ACK_BYTE.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, mmio_cs/read/write=0, mmio_addr=0, mmio_wr_data=0, busy=0. State=CMD, all byte counters=0.
- Reset is honoured in any state, including mid-frame or mid-response. A partial frame is discarded and no bus cycle is issued.
- Bus outputs are registered.
- FSM states and transitions:
  - CMD: rx_ready=1.
    - Accepted byte with bits[6:0]!=0: load NAK_BYTE, go to RESP with 1 byte pending.
    - Otherwise latch the direction bit and go to ADDR.
  - ADDR: rx_ready=1. Shift in 3 bytes with a 2-bit counter. After the 3rd byte, go to DATA if the command is a write, else BUS.
  - DATA: rx_ready=1. Shift in 4 bytes, then go to BUS.
  - BUS: rx_ready=0. mmio_cs=1 with mmio_read or mmio_write for exactly one cycle.
    - Read: capture mmio_rd_data into the 32-bit response shift register in that same cycle.
    - Write: load ACK_BYTE.
    - Go to RESP.
  - RESP: rx_ready=0, tx_valid=1.
    - On each tx_ready handshake, shift the next byte. For a read, the next byte is the next-lower byte of the captured word.
    - After the last byte (4 for read, 1 for write/NAK), tx_valid drops in the following cycle and the FSM returns to CMD.
- Latency: if the last frame byte is accepted in cycle N, mmio_cs is high in cycle N+1 and tx_valid rises in cycle N+2.
- mmio_addr and mmio_wr_data hold their last values outside BUS. mmio_cs/read/write are 0 outside BUS.
- mmio_read and mmio_write are never high simultaneously.
- tx_ready high while tx_valid=0: no effect.
- rx_valid held high during BUS/RESP: byte is not consumed (rx_ready=0).
- Back-to-back frames: the next CMD byte can be accepted in the cycle after the final tx handshake completes.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - A 20-bit idle counter runs in ADDR and DATA.
  - It clears on every accepted rx byte.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to CMD, the partial frame is dropped, no bus cycle and no response are issued.
  - The counter is held at 0 in other states.
- FRAME_TIMEOUT_EN undefined: no counter is instantiated; a stalled frame waits indefinitely.

Decomposition:
- Package fpro_bridge_pkg holds:
  - the state enum (CMD, ADDR, DATA, BUS, RESP);
  - the CMD bit positions (WR_BIT=7);
  - ACK/NAK defaults;
  - the address byte count (3) and data byte count (4).
- One natural sub-module: fpro_bridge_tx_shift, a 32-bit response shift register with byte counter and valid/ready output stage.
- Parser and bus FSM stay in the top module.

Test Plan:
- Write: bytes 80 00 00 A5 12 34 56 78 -> one cycle of mmio_cs=1, mmio_write=1, mmio_addr=21'h0000A5, mmio_wr_data=32'h12345678; tx sequence A5.
- Read: bytes 00 00 01 40; mmio_rd_data=32'hDEADBEEF during the cs cycle -> mmio_read=1, mmio_addr=21'h000140; tx sequence DE AD BE EF.
- Malformed: byte 41 -> no bus cycle; tx 5A; next valid read frame processed normally.
- Backpressure: read frame with tx_ready low for 10 cycles between each byte -> tx_data stable while stalled; rx_ready=0 throughout RESP; all 4 bytes delivered in order.
- Reset mid-frame: assert reset after 2 address bytes -> all outputs at reset values; no bus cycle; a following full write frame executes correctly.
- FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=100: send 80 00, then idle 100 cycles -> busy=0, no mmio_cs pulse, no tx byte; a following read frame executes correctly.
